// File: rtl/p2l_pkg.sv
// Shared types and constants for the pulse-to-level converter.
package p2l_pkg;

   // Controller states: IDLE (L=0), HOLD (stretching), LATCH (toggled high)
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_LATCH = 2'd2
   } p2l_state_t;

   // Mode input encodings
   localparam logic MODE_STRETCH = 1'b0;
   localparam logic MODE_TOGGLE  = 1'b1;

endpackage : p2l_pkg

// File: rtl/p2l_hold_counter.sv
// Loadable down-counter used to time the stretch interval.
// Load has priority over decrement; the count saturates at zero.
module p2l_hold_counter #(
   parameter int HOLD_W = 8
) (
   input  logic              CLK,
   input  logic              rstn,
   input  logic              i_load,
   input  logic [HOLD_W-1:0] i_load_val,
   input  logic              i_dec,
   output logic              o_zero
);

   localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] CNT_ZERO = HOLD_W'(0);

   logic [HOLD_W-1:0] r_cnt;
   logic              w_zero;

   assign w_zero = (r_cnt == CNT_ZERO);
   assign o_zero = w_zero;

   // Counter register: load, else decrement (never below zero), else hold
   always_ff @(posedge CLK) begin
      if (!rstn) begin
         r_cnt <= CNT_ZERO;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && !w_zero) begin
         r_cnt <= r_cnt - CNT_ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule : p2l_hold_counter

// File: rtl/pulse_to_level.sv
// Converts single-cycle request pulses into levels.
// Stretch mode holds L for max(hold_len,1) cycles per event; toggle mode
// flips L per event. rise/fall/dropped are registered one-cycle strobes.
module pulse_to_level
   import p2l_pkg::*;
#(
   parameter int HOLD_W    = 8,
   parameter bit RETRIGGER = 1'b1
) (
   input  logic              CLK,
   input  logic              rstn,
   input  logic              P,
   input  logic              mode,
   input  logic [HOLD_W-1:0] hold_len,
   input  logic              clr,
   output logic              L,
   output logic              rise,
   output logic              fall,
   output logic              dropped
);

   localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] CNT_ZERO = HOLD_W'(0);

   p2l_state_t        r_state;
   p2l_state_t        w_state_next;
   logic              r_p_q;
   logic              r_mode_q;
   logic              r_l;
   logic              r_rise;
   logic              r_fall;
   logic              r_dropped;

   logic              w_event;
   logic              w_mode_eff;
   logic [HOLD_W-1:0] w_hold_load;
   logic              w_cnt_load;
   logic [HOLD_W-1:0] w_cnt_load_val;
   logic              w_cnt_dec;
   logic              w_cnt_zero;
   logic              w_drop_next;
   logic              w_l_next;

   // A level held for several cycles is one event: only the rising edge counts
   assign w_event = P & ~r_p_q;

   // Mode governing the current activity: live while idle, frozen once active
   assign w_mode_eff = (r_state == S_IDLE) ? mode : r_mode_q;

   // hold_len of zero behaves like one cycle of hold
   assign w_hold_load = (hold_len == CNT_ZERO) ? CNT_ZERO : (hold_len - CNT_ONE);

   // L is high in every state except IDLE
   assign w_l_next = (w_state_next != S_IDLE);

   p2l_hold_counter #(
      .HOLD_W (HOLD_W)
   ) u_hold_counter (
      .CLK        (CLK),
      .rstn       (rstn),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   // Input history: previous P for edge detect, mode tracked only while idle
   always_ff @(posedge CLK) begin
      if (!rstn) begin
         r_p_q    <= 1'b0;
         r_mode_q <= MODE_STRETCH;
      end else begin
         r_p_q <= P;
         if (r_state == S_IDLE) begin
            r_mode_q <= mode;
         end else begin
            r_mode_q <= r_mode_q;
         end
      end
   end

   // State register
   always_ff @(posedge CLK) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state, counter control and drop strobe; clr overrides any event
   always_comb begin
      w_state_next   = r_state;
      w_cnt_load     = 1'b0;
      w_cnt_load_val = w_hold_load;
      w_cnt_dec      = 1'b0;
      w_drop_next    = 1'b0;
      if (clr) begin
         w_state_next   = S_IDLE;
         w_cnt_load     = 1'b1;
         w_cnt_load_val = CNT_ZERO;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_event) begin
                  if (w_mode_eff == MODE_TOGGLE) begin
                     w_state_next = S_LATCH;
                  end else begin
                     w_state_next = S_HOLD;
                     w_cnt_load   = 1'b1;
                  end
               end else begin
                  w_state_next = S_IDLE;
               end
            end
            S_HOLD: begin
               if (w_event && RETRIGGER) begin
                  // Reload without leaving HOLD: L stays high, no strobes
                  w_cnt_load   = 1'b1;
                  w_state_next = S_HOLD;
               end else begin
                  // Without retrigger the event is flagged and the countdown runs on
                  w_drop_next = w_event;
                  if (w_cnt_zero) begin
                     w_state_next = S_IDLE;
                  end else begin
                     w_cnt_dec    = 1'b1;
                     w_state_next = S_HOLD;
                  end
               end
            end
            S_LATCH: begin
               if (w_event) begin
                  w_state_next = S_IDLE;
               end else begin
                  w_state_next = S_LATCH;
               end
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   // Registered level and edge strobes; reset clears them without a fall strobe
   always_ff @(posedge CLK) begin
      if (!rstn) begin
         r_l       <= 1'b0;
         r_rise    <= 1'b0;
         r_fall    <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_l       <= w_l_next;
         r_rise    <= w_l_next & ~r_l;
         r_fall    <= ~w_l_next & r_l;
         r_dropped <= w_drop_next;
      end
   end

   assign L       = r_l;
   assign rise    = r_rise;
   assign fall    = r_fall;
   assign dropped = r_dropped;

endmodule : pulse_to_level

// File: tb/tb_pulse_to_level.sv
// Directed bench for pulse_to_level: a retrigger build (u_rt) and a
// non-retrigger build (u_nr) share the same inputs.
module tb_pulse_to_level;

   logic       CLK;
   logic       rstn;
   logic       P;
   logic       mode;
   logic [7:0] hold_len;
   logic       clr;
   logic       l_rt, rise_rt, fall_rt, drop_rt;
   logic       l_nr, rise_nr, fall_nr, drop_nr;

   int checks = 0;
   int errors = 0;

   pulse_to_level #(.HOLD_W(8), .RETRIGGER(1'b1)) u_rt (
      .CLK(CLK), .rstn(rstn), .P(P), .mode(mode), .hold_len(hold_len), .clr(clr),
      .L(l_rt), .rise(rise_rt), .fall(fall_rt), .dropped(drop_rt)
   );

   pulse_to_level #(.HOLD_W(8), .RETRIGGER(1'b0)) u_nr (
      .CLK(CLK), .rstn(rstn), .P(P), .mode(mode), .hold_len(hold_len), .clr(clr),
      .L(l_nr), .rise(rise_nr), .fall(fall_nr), .dropped(drop_nr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       rstn;
      logic       clr;
      logic       p;
      logic       mode;
      logic [7:0] hl;
      logic       l;
      logic       rise;
      logic       fall;
      logic       drop;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic p, input logic m, input logic [7:0] h);
      rstn     = r;
      clr      = c;
      P        = p;
      mode     = m;
      hold_len = h;
   endtask

   // One clock edge, then settle away from the edge before sampling
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_rt(input string nm, input logic l, input logic r, input logic f, input logic d);
      chk({nm, ".rt.L"}, l_rt, l);
      chk({nm, ".rt.rise"}, rise_rt, r);
      chk({nm, ".rt.fall"}, fall_rt, f);
      chk({nm, ".rt.dropped"}, drop_rt, d);
   endtask

   task automatic chk_nr(input string nm, input logic l, input logic r, input logic f, input logic d);
      chk({nm, ".nr.L"}, l_nr, l);
      chk({nm, ".nr.rise"}, rise_nr, r);
      chk({nm, ".nr.fall"}, fall_nr, f);
      chk({nm, ".nr.dropped"}, drop_nr, d);
   endtask

   initial begin
      int n;

      // rstn clr p mode hl | L rise fall drop   (outputs after the edge)
      // Reset with P high, then the first edge after release is an event
      tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0});
      // hold_len = 0 gives a single-cycle level
      tv.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      // Stretch hold_len = 5: five cycles high
      tv.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0});
      // Toggle: long P is one event; mode change while latched is ignored
      tv.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0});
      // Back in IDLE the new mode (stretch, 2 cycles) is honoured
      tv.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0});
      tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0});

      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].rstn, tv[i].clr, tv[i].p, tv[i].mode, tv[i].hl);
         tick();
         chk_rt($sformatf("vec%0d", i), tv[i].l, tv[i].rise, tv[i].fall, tv[i].drop);
         chk_nr($sformatf("vec%0d", i), tv[i].l, tv[i].rise, tv[i].fall, tv[i].drop);
      end

      // Retrigger: hold_len=4, events at edges 0 and 3
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd4); tick();
      chk_rt("rt0", 1'b1, 1'b1, 1'b0, 1'b0);
      chk_nr("rt0", 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd4); tick();
      chk_rt("rt1", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_nr("rt1", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_rt("rt2", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_nr("rt2", 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd4); tick();
      chk_rt("rt3", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_nr("rt3", 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd4); tick();
      chk_rt("rt4", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_nr("rt4", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_rt("rt5", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_rt("rt6", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_rt("rt7", 1'b0, 1'b0, 1'b1, 1'b0);
      chk_nr("rt7", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      // clr during a long stretch with a coincident event
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd20); tick();
      chk_rt("clr0", 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd20);
      for (int k = 1; k < 5; k++) tick();
      chk_rt("clr4", 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 8'd20); tick();
      chk_rt("clr5", 1'b0, 1'b0, 1'b1, 1'b0);
      chk_nr("clr5", 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd20); tick();
      chk_rt("clr6", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_nr("clr6", 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd20); tick();
      chk_rt("clr7", 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset mid-hold: no fall strobe
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd10); tick();
      chk_rt("mrst0", 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd10); tick();
      chk_rt("mrst1", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_nr("mrst1", 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd10); tick();
      chk_rt("mrst2", 1'b0, 1'b0, 1'b0, 1'b0);

      // Maximum hold: hold_len=255 keeps L high for exactly 255 cycles
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd255); tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
      n = 0;
      while (l_rt && n < 300) begin
         n++;
         tick();
      end
      checks++;
      if (n != 255) begin
         errors++;
         $display("FAIL maxhold got %0d cycles expected 255", n);
      end
      chk("maxhold.fall", fall_rt, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pulse_to_level
